if_id_queue: RTL and testbench

Parametrised successor to the single-entry IF/ID latch: a DEPTH-entry instruction queue between fetch and decode with valid/ready handshakes on both sides, a jump-flush, and zero-word bubbles when empty. IF pushes {pc, inst} pairs and ID pops them in order, so fetch can run ahead of decode stalls without the `stall` vector decode between stages.

---
 rtl/if_id_queue_pkg.sv | 9 +
 rtl/if_id_queue_mem.sv | 24 ++
 rtl/if_id_queue.sv | 91 +++++++++
 tb/tb_if_id_queue.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue: default depth and the
// bubble encoding that decode treats as a NOP.
package if_id_queue_pkg;

  localparam int          IF_ID_QUEUE_DEPTH = 4;
  localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INST       = ZERO_WORD;

endpackage

// File: rtl/if_id_queue_mem.sv
// Register array for the IF/ID queue: one synchronous write port and one
// asynchronous read port. No reset; occupancy is tracked by the controller.
module if_id_queue_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry IF/ID instruction queue with valid/ready on both sides, flush,
// and zero bubbles when empty. Define IF_ID_QUEUE_BYPASS_EN for zero-latency
// pass-through while the queue is empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = IF_ID_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      pc_in,
  input  logic [INST_WIDTH-1:0]      inst_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      pc_out,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int PTR_WIDTH  = $clog2(DEPTH);
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);
  localparam int DATA_WIDTH = ADDR_WIDTH + INST_WIDTH;

  logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  empty;
  logic                  bypass_active;
  logic                  push, q_push, q_pop;

  assign empty    = (count == '0);
  assign in_ready = (count < CNT_WIDTH'(DEPTH)) && !flush_in;
  assign push     = in_valid && in_ready;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass_active = empty && in_valid && !flush_in;
`else
  assign bypass_active = 1'b0;
`endif

  // A bypassed pair that ID takes immediately never occupies a slot.
  assign q_push = push && !(bypass_active && out_ready);
  assign q_pop  = !empty && out_ready;

  assign out_valid = !empty || bypass_active;
  assign count_out = count;

  always_comb begin
    pc_out   = '0;
    inst_out = INST_WIDTH'(BUBBLE_INST);
    if (bypass_active) begin
      pc_out   = pc_in;
      inst_out = inst_in;
    end else if (!empty) begin
      pc_out   = head_data[DATA_WIDTH-1:INST_WIDTH];
      inst_out = head_data[INST_WIDTH-1:0];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (q_push) wr_ptr <= wr_ptr + 1'b1;
      if (q_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_WIDTH'(q_push) - CNT_WIDTH'(q_pop);
    end
  end

  if_id_queue_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .we     (q_push && !rst),
    .wr_addr(wr_ptr),
    .wr_data({pc_in, inst_in}),
    .rd_addr(rd_ptr),
    .rd_data(head_data)
  );

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_if_id_queue;

  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, flush_in, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [AW-1:0] pc_in, pc_out;
  logic [IW-1:0] inst_in, inst_out;
  logic [CW-1:0] count_out;

  int checks = 0;
  int errors = 0;

  logic [AW+IW-1:0] model_q[$];
  bit               model_live = 1'b0;

  always #5 clk = ~clk;

  if_id_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush_in (flush_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pc_in    (pc_in),
    .inst_in  (inst_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pc_out   (pc_out),
    .inst_out (inst_out),
    .count_out(count_out)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and hold for a full cycle.
  task automatic applyStimulus(input bit r, input bit fl, input bit v,
                               input logic [AW-1:0] pc, input logic [IW-1:0] inst,
                               input bit rdy);
    rst = r; flush_in = fl; in_valid = v; pc_in = pc; inst_in = inst; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered list of accepted pairs, updated from the
  // sampled inputs at each edge.
  always @(posedge clk) begin
    int sz;
    bit do_push, do_pop;
    sz = model_q.size();
    if (rst) begin
      model_q.delete();
      model_live = 1'b1;
    end else if (flush_in) begin
      model_q.delete();
    end else begin
      do_push = in_valid && (sz < DEPTH);
      do_pop  = out_ready && (sz > 0);
`ifdef IF_ID_QUEUE_BYPASS_EN
      if (sz == 0 && in_valid && out_ready) do_push = 1'b0;
`endif
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc_in, inst_in});
    end
  end

  // Monitor: compares every visible output mid-cycle.
  always @(negedge clk) begin
    int sz;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
    logic [IW-1:0] exp_inst;
    if (model_live) begin
      sz        = model_q.size();
      exp_valid = (sz != 0);
      exp_pc    = '0;
      exp_inst  = '0;
      if (sz != 0) begin
        exp_pc   = model_q[0][AW+IW-1:IW];
        exp_inst = model_q[0][IW-1:0];
      end
`ifdef IF_ID_QUEUE_BYPASS_EN
      if (sz == 0 && in_valid && !flush_in) begin
        exp_valid = 1'b1;
        exp_pc    = pc_in;
        exp_inst  = inst_in;
      end
`endif
      checkOutput("count_out", 64'(count_out), 64'(sz));
      checkOutput("in_ready",  64'(in_ready),  64'((sz < DEPTH) && !flush_in));
      checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
      checkOutput("pc_out",    64'(pc_out),    64'(exp_pc));
      checkOutput("inst_out",  64'(inst_out),  64'(exp_inst));
    end
  end

  initial begin
    logic [AW-1:0] pc;
    rst = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = '0; inst_in = '0;

    // Reset then idle.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Fill to full, offer one extra push while full, then drain.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, AW'(i * 4), 32'h0000_0013, 0);
    applyStimulus(0, 0, 1, 32'hDEAD_0000, 32'h1111_1111, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1);

    // Continuous push with continuous pop across pointer wrap.
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 1, 32'h100 + AW'(i * 4), 32'hA000_0000 + IW'(i), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Build count 2, then simultaneous push and pop.
    applyStimulus(0, 0, 1, 32'h300, 32'h33, 0);
    applyStimulus(0, 0, 1, 32'h304, 32'h34, 0);
    applyStimulus(0, 0, 1, 32'h308, 32'h35, 1);
    applyStimulus(0, 0, 1, 32'h30C, 32'h36, 1);

    // Flush with entries present and a push offered, then a fresh push.
    applyStimulus(0, 0, 1, 32'h310, 32'h37, 0);
    applyStimulus(0, 1, 1, 32'h314, 32'h38, 1);
    applyStimulus(0, 0, 1, 32'h400, 32'h40, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Empty queue presented with a pair while ID is ready.
    applyStimulus(0, 0, 1, 32'h200, 32'h0000_0013, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Reset mid-operation takes priority over flush.
    applyStimulus(0, 0, 1, 32'h500, 32'h50, 0);
    applyStimulus(0, 0, 1, 32'h504, 32'h51, 0);
    applyStimulus(1, 1, 1, 32'h508, 32'h52, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Random traffic.
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 9) < 7), pc, $urandom(),
                    ($urandom_range(0, 1) == 1));
      pc = pc + 4;
    end
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
